// File: rtl/instr_prefetch_buffer_if.sv
// Instruction-memory request/grant/rvalid bus and IF-stage valid/ready bus of the prefetch buffer.
// master is the prefetch side; slave is the memory plus IF stage.
interface instr_prefetch_buffer_if #(
    parameter int unsigned WORD_WIDTH = 32
);
    logic                  instr_req_o;
    logic [WORD_WIDTH-1:0] instr_addr_o;
    logic                  instr_gnt_i;
    logic                  instr_rvalid_i;
    logic [WORD_WIDTH-1:0] instr_rdata_i;
    logic                  fetch_valid_o;
    logic [WORD_WIDTH-1:0] fetch_rdata_o;
    logic [WORD_WIDTH-1:0] fetch_addr_o;
    logic                  fetch_ready_i;

    modport master (
        output instr_req_o,
        output instr_addr_o,
        input  instr_gnt_i,
        input  instr_rvalid_i,
        input  instr_rdata_i,
        output fetch_valid_o,
        output fetch_rdata_o,
        output fetch_addr_o,
        input  fetch_ready_i
    );

    modport slave (
        input  instr_req_o,
        input  instr_addr_o,
        output instr_gnt_i,
        output instr_rvalid_i,
        output instr_rdata_i,
        input  fetch_valid_o,
        input  fetch_rdata_o,
        input  fetch_addr_o,
        output fetch_ready_i
    );
endinterface

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: credit-limited memory requests, in-order response FIFO,
// branch redirect that flushes buffered words and drops responses still in flight.
module instr_prefetch_buffer #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_en_i,
    input  logic [WORD_WIDTH-1:0]   pc_start_address_i,
    input  logic                    branch_i,
    input  logic [WORD_WIDTH-1:0]   branch_addr_i,
    output logic                    busy_o,
    instr_prefetch_buffer_if.master bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [PTR_W-1:0]      PTR_LAST   = PTR_W'(DEPTH - 1);
    localparam logic [WORD_WIDTH-1:0] ADDR_STEP  = WORD_WIDTH'(4);
    localparam logic [WORD_WIDTH-1:0] ALIGN_MASK = ~WORD_WIDTH'(3);

    typedef enum logic [0:0] {
        FETCH       = 1'b0,
        BRANCH_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] addr;
        logic [WORD_WIDTH-1:0] data;
    } entry_t;

    state_t                state, state_n;
    logic                  active;
    logic                  pending, pending_n;
    logic [WORD_WIDTH-1:0] fetch_addr, fetch_addr_n;
    logic [WORD_WIDTH-1:0] target, target_n;
    logic [CNT_W-1:0]      outstanding, outstanding_n;
    logic [CNT_W-1:0]      discard, discard_n;
    logic [CNT_W-1:0]      count, count_n;
    logic [PTR_W-1:0]      rd_ptr, rd_ptr_n, wr_ptr, wr_ptr_n;
    logic [PTR_W-1:0]      aq_rd, aq_rd_n, aq_wr, aq_wr_n;

    entry_t                fifo [DEPTH];
    logic [WORD_WIDTH-1:0] aq   [DEPTH];

    logic                  req, granted, resp, push, pop, credit;
    logic [SUM_W-1:0]      committed;
    logic [WORD_WIDTH-1:0] start_aligned, branch_aligned;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign start_aligned  = pc_start_address_i & ALIGN_MASK;
    assign branch_aligned = branch_addr_i & ALIGN_MASK;

    // Next-state, counters and handshake decode
    always_comb begin
        state_n       = state;
        pending_n     = pending;
        fetch_addr_n  = fetch_addr;
        target_n      = target;
        outstanding_n = outstanding;
        discard_n     = discard;
        count_n       = count;
        rd_ptr_n      = rd_ptr;
        wr_ptr_n      = wr_ptr;
        aq_rd_n       = aq_rd;
        aq_wr_n       = aq_wr;

        resp      = bus.instr_rvalid_i && (outstanding != '0);
        pop       = (count != '0) && bus.fetch_ready_i && !branch_i;
        // A word leaving the FIFO this cycle frees its credit immediately, giving 1 instr/cycle.
        committed = SUM_W'(outstanding) + SUM_W'(count) - SUM_W'(pop);
        credit    = committed < SUM_W'(DEPTH);
        req       = active && (pending || ((state == FETCH) && fetch_en_i && credit && !branch_i));
        granted   = req && bus.instr_gnt_i;
        push      = resp && (discard == '0) && !branch_i;

        outstanding_n = outstanding + CNT_W'(granted) - CNT_W'(resp);
        pending_n     = req && !granted;

        if (granted) begin
            fetch_addr_n = fetch_addr + ADDR_STEP;
            aq_wr_n      = ptr_inc(aq_wr);
        end
        if (resp) begin
            aq_rd_n = ptr_inc(aq_rd);
        end
        if (resp && (discard != '0)) begin
            discard_n = discard - CNT_W'(1);
        end
        if (push) begin
            wr_ptr_n = ptr_inc(wr_ptr);
        end
        if (pop) begin
            rd_ptr_n = ptr_inc(rd_ptr);
        end
        count_n = count + CNT_W'(push) - CNT_W'(pop);

        unique case (state)
            FETCH: begin
            end
            BRANCH_WAIT: begin
                // The stale request finally leaves; its response must be dropped too.
                if (granted) begin
                    discard_n    = discard_n + CNT_W'(1);
                    fetch_addr_n = target;
                    state_n      = FETCH;
                end
            end
            default: state_n = FETCH;
        endcase

        if (branch_i) begin
            count_n   = '0;
            rd_ptr_n  = '0;
            wr_ptr_n  = '0;
            discard_n = outstanding_n;
            target_n  = branch_aligned;
            if (pending_n) begin
                state_n = BRANCH_WAIT;
            end else begin
                state_n      = FETCH;
                fetch_addr_n = branch_aligned;
            end
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            active      <= 1'b0;
            pending     <= 1'b0;
            fetch_addr  <= start_aligned;
            target      <= '0;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            aq_rd       <= '0;
            aq_wr       <= '0;
        end else begin
            state       <= state_n;
            active      <= 1'b1;
            pending     <= pending_n;
            fetch_addr  <= fetch_addr_n;
            target      <= target_n;
            outstanding <= outstanding_n;
            discard     <= discard_n;
            count       <= count_n;
            rd_ptr      <= rd_ptr_n;
            wr_ptr      <= wr_ptr_n;
            aq_rd       <= aq_rd_n;
            aq_wr       <= aq_wr_n;
        end
    end

    // Instruction FIFO and granted-address queue storage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo[PTR_W'(i)] <= '0;
                aq[PTR_W'(i)]   <= '0;
            end
        end else begin
            if (push) begin
                fifo[wr_ptr] <= '{addr: aq[aq_rd], data: bus.instr_rdata_i};
            end
            if (granted) begin
                aq[aq_wr] <= fetch_addr;
            end
        end
    end

    assign bus.instr_req_o   = req;
    assign bus.instr_addr_o  = fetch_addr;
    assign bus.fetch_valid_o = (count != '0);
    assign bus.fetch_rdata_o = fifo[rd_ptr].data;
    assign bus.fetch_addr_o  = fifo[rd_ptr].addr;
    assign busy_o            = (outstanding != '0) || (discard != '0);

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Scoreboard bench for instr_prefetch_buffer: a memory model answers grants in order,
// kept words are queued as expected IF-stage output and compared when popped.
module tb_instr_prefetch_buffer;
    localparam int unsigned WORD_WIDTH = 32;
    localparam int unsigned DEPTH      = 2;

    typedef struct {
        logic [31:0] addr;
        bit          live;
        int          due;
    } mem_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        branch;
    logic        busy;
    logic [31:0] pc_start;
    logic [31:0] branch_addr;

    instr_prefetch_buffer_if #(.WORD_WIDTH(WORD_WIDTH)) bus ();

    instr_prefetch_buffer #(.WORD_WIDTH(WORD_WIDTH), .DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .fetch_en_i         (fetch_en),
        .pc_start_address_i (pc_start),
        .branch_i           (branch),
        .branch_addr_i      (branch_addr),
        .busy_o             (busy),
        .bus                (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    mem_t        mem_q[$];
    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          grants, pops, page;
    bit          rst_drv, en_drv, br_drv, gnt_drv, rdy_drv, rsp_en;
    bit          awaiting, prev_hold;
    logic [31:0] br_tgt, exp_req, prev_addr, last_gnt_addr, last_pop_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, sample 1ns later, update the model for the coming posedge.
    task automatic cycle();
        mem_t m;
        exp_t e;
        bit   rv;
        @(negedge clk);
        rst                = rst_drv;
        fetch_en           = en_drv;
        branch             = br_drv;
        branch_addr        = br_tgt;
        bus.instr_gnt_i    = gnt_drv;
        bus.fetch_ready_i  = rdy_drv;
        rv                 = !rst_drv && rsp_en && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        bus.instr_rvalid_i = rv;
        bus.instr_rdata_i  = rv ? mem_word(mem_q[0].addr) : 32'hDEAD_BEEF;
        #1;
        if (rst_drv) begin
            mem_q.delete();
            sb_q.delete();
            exp_req   = pc_start & 32'hFFFF_FFFC;
            awaiting  = 1'b0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("req_held", 32'(bus.instr_req_o), 32'd1);
                check("addr_held", bus.instr_addr_o, prev_addr);
            end
            if (rv) begin
                m = mem_q.pop_front();
                if (m.live && !br_drv) begin
                    e.addr = m.addr;
                    e.data = mem_word(m.addr);
                    sb_q.push_back(e);
                end
            end
            if (bus.fetch_valid_o && rdy_drv && !br_drv) begin
                pops++;
                last_pop_addr = bus.fetch_addr_o;
                check("pop_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("fetch_addr", bus.fetch_addr_o, e.addr);
                    check("fetch_rdata", bus.fetch_rdata_o, e.data);
                end
            end
            if (bus.instr_req_o && gnt_drv) begin
                grants++;
                last_gnt_addr = bus.instr_addr_o;
                if (awaiting && (bus.instr_addr_o == exp_req)) awaiting = 1'b0;
                m.addr = bus.instr_addr_o;
                m.live = !awaiting;
                m.due  = cyc + 1;
                if (m.live) begin
                    check("req_addr", bus.instr_addr_o, exp_req);
                    exp_req = exp_req + 32'd4;
                end
                mem_q.push_back(m);
            end
            prev_hold = bus.instr_req_o && !gnt_drv;
            prev_addr = bus.instr_addr_o;
            if (br_drv) begin
                sb_q.delete();
                foreach (mem_q[i]) mem_q[i].live = 1'b0;
                exp_req  = br_tgt & 32'hFFFF_FFFC;
                awaiting = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset(input logic [31:0] start);
        pc_start = start;
        rst_drv  = 1'b1;
        br_drv   = 1'b0;
        cycle();
        cycle();
        check("rst_req", 32'(bus.instr_req_o), 32'd0);
        check("rst_addr", bus.instr_addr_o, start & 32'hFFFF_FFFC);
        check("rst_valid", 32'(bus.fetch_valid_o), 32'd0);
        check("rst_rdata", bus.fetch_rdata_o, 32'd0);
        check("rst_faddr", bus.fetch_addr_o, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_drv = 1'b0;
        grants  = 0;
        pops    = 0;
    endtask

    initial begin
        rst = 1'b1; fetch_en = 1'b0; branch = 1'b0; branch_addr = '0; pc_start = '0;
        bus.instr_gnt_i = 1'b0; bus.instr_rvalid_i = 1'b0; bus.instr_rdata_i = '0;
        bus.fetch_ready_i = 1'b0;
        en_drv = 1'b1; gnt_drv = 1'b1; rdy_drv = 1'b1; rsp_en = 1'b1; br_drv = 1'b0;
        br_tgt = '0; page = 0; last_gnt_addr = '0; last_pop_addr = '0;

        // Streaming from 0x80 at one instruction per cycle
        do_reset(32'h80);
        run(9);
        check("t1_grants", 32'(grants), 32'd8);
        check("t1_pops", 32'(pops), 32'd6);
        check("t1_last_pop", last_pop_addr, 32'h94);

        // IF stage stalled: credit stops requests after DEPTH grants
        rdy_drv = 1'b0;
        do_reset(32'h80);
        run(6);
        check("t2_grants", 32'(grants), 32'd2);
        check("t2_req_off", 32'(bus.instr_req_o), 32'd0);
        check("t2_valid", 32'(bus.fetch_valid_o), 32'd1);
        rdy_drv = 1'b1;
        run(1);
        check("t2_restart", last_gnt_addr, 32'h88);
        run(6);

        // Grant withheld while fetch_en drops
        gnt_drv = 1'b0;
        do_reset(32'h80);
        run(2);
        en_drv = 1'b0;
        run(3);
        check("t3_req", 32'(bus.instr_req_o), 32'd1);
        check("t3_addr", bus.instr_addr_o, 32'h80);
        gnt_drv = 1'b1;
        run(1);
        check("t3_grants", 32'(grants), 32'd1);
        run(1);
        check("t3_req_off", 32'(bus.instr_req_o), 32'd0);
        run(2);
        check("t3_pop", last_pop_addr, 32'h80);
        en_drv = 1'b1;

        // Branch with two responses outstanding
        rdy_drv = 1'b0; rsp_en = 1'b0;
        do_reset(32'h80);
        run(4);
        br_drv = 1'b1; br_tgt = 32'h203; gnt_drv = 1'b0;
        run(1);
        br_drv = 1'b0;
        run(1);
        check("t4_valid", 32'(bus.fetch_valid_o), 32'd0);
        check("t4_busy", 32'(busy), 32'd1);
        rsp_en = 1'b1;
        run(3);
        check("t4_busy_low", 32'(busy), 32'd0);
        check("t4_req_addr", bus.instr_addr_o, 32'h200);
        gnt_drv = 1'b1; rdy_drv = 1'b1;
        run(1);
        check("t4_gnt", last_gnt_addr, 32'h200);
        gnt_drv = 1'b0;
        run(3);
        check("t4_pop", last_pop_addr, 32'h200);

        // Branch while a request to 0x90 waits for grant, retargeted to 0x300
        do_reset(32'h90);
        run(2);
        br_drv = 1'b1; br_tgt = 32'h200;
        run(1);
        br_tgt = 32'h300;
        run(1);
        br_drv = 1'b0;
        run(1);
        check("t5_req", 32'(bus.instr_req_o), 32'd1);
        check("t5_addr", bus.instr_addr_o, 32'h90);
        gnt_drv = 1'b1;
        run(1);
        check("t5_stale_gnt", last_gnt_addr, 32'h90);
        run(1);
        check("t5_gnt", last_gnt_addr, 32'h300);
        gnt_drv = 1'b0;
        run(3);
        check("t5_pop", last_pop_addr, 32'h300);

        // Address wrap, then reset with the FIFO full
        gnt_drv = 1'b1;
        do_reset(32'hFFFF_FFFC);
        run(3);
        check("t6_wrap", last_gnt_addr, 32'h0);
        rdy_drv = 1'b0;
        run(4);
        check("t6_full", 32'(bus.fetch_valid_o), 32'd1);
        rdy_drv = 1'b1;
        do_reset(32'h40);

        // Random handshakes and redirects, each redirect to a fresh page
        for (int i = 0; i < 400; i++) begin
            gnt_drv = ($urandom_range(0, 3) != 0);
            rdy_drv = ($urandom_range(0, 3) != 0);
            rsp_en  = ($urandom_range(0, 4) != 0);
            en_drv  = ($urandom_range(0, 7) != 0);
            br_drv  = ($urandom_range(0, 19) == 0);
            if (br_drv) begin
                page++;
                br_tgt = 32'h4000_0000 + 32'(page << 12) + 32'($urandom_range(0, 3));
            end
            cycle();
        end

        // Drain
        br_drv = 1'b0; en_drv = 1'b0; gnt_drv = 1'b1; rdy_drv = 1'b1; rsp_en = 1'b1;
        run(10);
        check("drain_sb", 32'(sb_q.size()), 32'd0);
        check("drain_mem", 32'(mem_q.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_valid", 32'(bus.fetch_valid_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/instr_prefetch_buffer.md
# instr_prefetch_buffer

Instruction prefetch unit directly upstream of the IF stage. Owns the instruction-memory request/grant/rvalid handshake, keeps up to DEPTH requests in flight and buffers returned words with their addresses in a FIFO. Presents one instruction per cycle to the IF stage over a valid/ready interface. Redirects fetch on a taken branch/jump, flushing buffered words and discarding responses still in flight.

## Interface
- WORD_WIDTH, 32, data/address width
- DEPTH, 2, FIFO entries and max outstanding requests combined (2..8)

- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- fetch_en_i  in  1  allow new memory requests
- pc_start_address_i  in  WORD_WIDTH  fetch address loaded at reset
- branch_i  in  1  redirect fetch this cycle
- branch_addr_i  in  WORD_WIDTH  redirect target; bits [1:0] forced to 0
- instr_req_o  out  1  memory request
- instr_addr_o  out  WORD_WIDTH  request address, word aligned
- instr_gnt_i  in  1  request accepted this cycle
- instr_rvalid_i  in  1  instr_rdata_i valid this cycle
- instr_rdata_i  in  WORD_WIDTH  returned instruction word
- fetch_valid_o  out  1  FIFO head valid
- fetch_rdata_o  out  WORD_WIDTH  instruction at FIFO head
- fetch_addr_o  out  WORD_WIDTH  address of that instruction
- fetch_ready_i  in  1  IF stage consumes head
- busy_o  out  1  outstanding != 0 or discard != 0

## Operation
- Reset values: instr_req_o 0, instr_addr_o = {pc_start_address_i[31:2],2'b00}, fetch_valid_o 0, fetch_rdata_o 0, fetch_addr_o 0, busy_o 0, FIFO empty, outstanding 0, discard 0, state FETCH.
- Credit: request allowed when outstanding + fifo_count < DEPTH.
- States: FETCH, BRANCH_WAIT.
- FETCH: instr_req_o = fetch_en_i && credit. On req && gnt: outstanding+1, fetch_addr_reg += 4 (mod 2^WORD_WIDTH, wraps 0xFFFFFFFC -> 0). Request address queue records each granted address.
- Once instr_req_o rises, it and instr_addr_o stay stable until instr_gnt_i, even if fetch_en_i drops or credit changes.
- On rvalid: outstanding-1. If discard > 0: discard-1, word dropped. Else word and its queued address pushed to FIFO.
- Pop when fetch_valid_o && fetch_ready_i && !branch_i.
- branch_i (priority over pop and push): FIFO cleared; discard <= outstanding + (gnt?1:0) - (rvalid?1:0) (rvalid in the branch cycle itself is dropped); target latched.
  - No ungranted request pending (or granted this cycle): next cycle fetch_addr_reg = target, stay FETCH.
  - Ungranted request pending: -> BRANCH_WAIT; keep req/old address until gnt; on gnt discard+1, fetch_addr_reg = target, -> FETCH.
- branch_i in BRANCH_WAIT overwrites latched target; discard accounting as above.
- Outstanding responses never exceed DEPTH, so a push never meets a full FIFO. rvalid with outstanding = 0 is ignored.
- fetch_en_i low: no new requests; in-flight responses still accepted and buffered.

## Timing
- instr_req_o earliest the first cycle after rst deasserts (fetch_en_i = 1).
- FIFO registered, no bypass: rvalid in cycle N -> fetch_valid_o in N+1.
- Redirect: branch_i in cycle N -> fetch_valid_o 0 in N+1. Request at target in N+1 (FETCH case). First target instruction valid at its rvalid + 1.
- Sustained throughput 1 instr/cycle with gnt always 1, rvalid 1 cycle after gnt, DEPTH >= 2.
- rst asserted mid-operation: all state back to reset values next cycle. In-flight responses after reset are not tracked (memory reset together with core).

## Test plan
- Reset with pc_start_address_i=0x80, fetch_en=1, gnt=1, rvalid one cycle later, ready=1 -> addresses 0x80,0x84,0x88 issued on consecutive cycles; fetch_addr_o sequence 0x80,0x84,0x88, one per cycle.
- ready=0 for 5 cycles, DEPTH=2 -> exactly 2 requests granted, then instr_req_o 0. Resume ready -> requests restart at 0x88.
- gnt held 0 for 3 cycles while fetch_en drops -> instr_req_o and instr_addr_o stable until gnt.
- branch_i to 0x203 with 2 outstanding -> both responses dropped; next request 0x200; first fetch_addr_o = 0x200; busy_o low after the last dropped response.
- branch_i while ungranted request to 0x90 pending -> 0x90 held until gnt, its response dropped, then request 0x200. Second branch to 0x300 during wait -> target 0x300.
- Wrap: start 0xFFFFFFFC -> next address 0x0. Reset asserted with FIFO full -> fetch_valid_o 0 and instr_req_o 0 next cycle.
